// File: rtl/bist_tpg_lfsr_pkg.sv
// Shared BIST definitions: generator FSM states, LFSR period arithmetic and
// primitive-polynomial tap masks, also used by the signature analyser.
package bist_pkg;

   localparam int MIN_WIDTH = 2;
   localparam int MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tpg_state_t;

   // Patterns per run: 2^width - 1, plus the all-zero state when extended.
   function automatic logic [32:0] lfsr_period(input int unsigned width, input bit ext_zero);
      return (33'd1 << width) - 33'd1 + {32'd0, ext_zero};
   endfunction

   // Bit k-1 set for polynomial term x^k; masks suit the shift-left Fibonacci step.
   function automatic logic [31:0] default_taps(input int unsigned width);
      case (width)
         2:       return 32'h0000_0003;
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/bist_tpg_lfsr_if.sv
// Pattern generator handshake: the BIST controller/consumer is the master,
// the generator is the slave.
interface bist_tpg_lfsr_if #(
   parameter int WIDTH = 3
);
   logic             start;
   logic [WIDTH-1:0] seed;
   logic             advance;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             busy;
   logic             complete;
   logic             seed_err;

   modport master (
      output start, seed, advance,
      input  data_out, data_valid, busy, complete, seed_err
   );

   modport slave (
      input  start, seed, advance,
      output data_out, data_valid, busy, complete, seed_err
   );
endinterface

// File: rtl/bist_lfsr_step.sv
// Combinational Fibonacci LFSR step (shift-left), with optional de Bruijn
// extension that splices the all-zero state into the cycle.
module bist_lfsr_step
   import bist_pkg::*;
#(
   parameter int               WIDTH    = 3,
   parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
   parameter bit               EXT_ZERO = 1'b0
) (
   input  logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] next
);
   logic [WIDTH-1:0] tapped;
   logic             fb;
   logic             z;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tapped[gi] = s[gi] & TAPS[gi];
   end

   assign fb = ^tapped;
   // Flipping feedback when the low bits are all zero routes 10..0 -> 0..0 -> 0..01.
   assign z    = EXT_ZERO && (s[WIDTH-2:0] == '0);
   assign next = {s[WIDTH-2:0], fb ^ z};
endmodule

// File: rtl/bist_tpg_lfsr.sv
// BIST test-pattern generator: seeds an LFSR on start, steps it on each
// accepted pattern and reports completion after one full period.
module bist_tpg_lfsr
   import bist_pkg::*;
#(
   parameter int               WIDTH    = 3,
   parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
   parameter bit               EXT_ZERO = 1'b0
) (
   input logic            clock,
   input logic            reset,
   bist_tpg_lfsr_if.slave bus
);
   localparam logic [32:0]      PERIOD   = lfsr_period(WIDTH, EXT_ZERO);
   localparam logic [WIDTH:0]   LAST_CNT = PERIOD[WIDTH:0] - {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONE_PAT  = {{(WIDTH-1){1'b0}}, 1'b1};

   tpg_state_t       state_reg;
   logic [WIDTH-1:0] s_reg;
   logic [WIDTH-1:0] s_next;
   logic [WIDTH:0]   count_reg;
   logic             valid_reg;
   logic             busy_reg;
   logic             complete_reg;
   logic             seed_err_reg;
   logic             zero_seed;

   bist_lfsr_step #(
      .WIDTH    (WIDTH),
      .TAPS     (TAPS),
      .EXT_ZERO (EXT_ZERO)
   ) u_step (
      .s    (s_reg),
      .next (s_next)
   );

   // A zero seed would lock a plain LFSR, so it is replaced by 0..01.
   assign zero_seed = !EXT_ZERO && (bus.seed == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         s_reg        <= ONE_PAT;
         count_reg    <= '0;
         valid_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         complete_reg <= 1'b0;
         seed_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_reg    <= RUN;
                  count_reg    <= '0;
                  valid_reg    <= 1'b1;
                  busy_reg     <= 1'b1;
                  complete_reg <= 1'b0;
                  seed_err_reg <= zero_seed;
                  s_reg        <= zero_seed ? ONE_PAT : bus.seed;
               end
            end
            RUN: begin
               if (bus.advance) begin
                  // Final pattern stays on data_out after the run ends.
                  if (count_reg == LAST_CNT) begin
                     state_reg    <= DONE;
                     valid_reg    <= 1'b0;
                     busy_reg     <= 1'b0;
                     complete_reg <= 1'b1;
                  end else begin
                     s_reg     <= s_next;
                     count_reg <= count_reg + {{WIDTH{1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out   = s_reg;
   assign bus.data_valid = valid_reg;
   assign bus.busy       = busy_reg;
   assign bus.complete   = complete_reg;
   assign bus.seed_err   = seed_err_reg;
endmodule

// File: tb/tb_bist_tpg_lfsr.sv
// Directed bench for bist_tpg_lfsr: 3-bit plain, 3-bit de Bruijn and 8-bit
// generators on a shared clock and reset.
module tb_bist_tpg_lfsr;
   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bist_tpg_lfsr_if #(.WIDTH(3)) bus3  ();
   bist_tpg_lfsr_if #(.WIDTH(3)) bus3z ();
   bist_tpg_lfsr_if #(.WIDTH(8)) bus8  ();

   bist_tpg_lfsr #(.WIDTH(3), .TAPS(3'b110), .EXT_ZERO(1'b0)) u_dut3 (
      .clock (clock), .reset (reset), .bus (bus3)
   );
   bist_tpg_lfsr #(.WIDTH(3), .TAPS(3'b110), .EXT_ZERO(1'b1)) u_dut3z (
      .clock (clock), .reset (reset), .bus (bus3z)
   );
   bist_tpg_lfsr #(.WIDTH(8), .TAPS(8'hB8), .EXT_ZERO(1'b0)) u_dut8 (
      .clock (clock), .reset (reset), .bus (bus8)
   );

   // Hand-derived sequences from seed 1.
   logic [2:0] exp7  [7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};
   logic [2:0] exp8z [8] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd0};
   logic [7:0] exp8  [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]   seen3;
      logic [255:0] seen8;
      int           acc, cyc, n, dups, zeros;
      logic         adv;

      reset = 1'b0;
      bus3.start  = 1'b0; bus3.seed  = '0; bus3.advance  = 1'b0;
      bus3z.start = 1'b0; bus3z.seed = '0; bus3z.advance = 1'b0;
      bus8.start  = 1'b0; bus8.seed  = '0; bus8.advance  = 1'b0;
      repeat (2) tick();
      check_eq("rst_data",     32'(bus3.data_out),   32'd1);
      check_eq("rst_valid",    32'(bus3.data_valid), 32'd0);
      check_eq("rst_busy",     32'(bus3.busy),       32'd0);
      check_eq("rst_complete", 32'(bus3.complete),   32'd0);
      check_eq("rst_seed_err", 32'(bus3.seed_err),   32'd0);
      check_eq("rst_data8",    32'(bus8.data_out),   32'h01);
      reset = 1'b1;
      tick();

      // Unstalled run; start raised alongside the final advance must lose.
      bus3.seed = 3'b001; bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0; bus3.advance = 1'b1;
      check_eq("t1_busy",     32'(bus3.busy),     32'd1);
      check_eq("t1_seed_err", 32'(bus3.seed_err), 32'd0);
      for (int i = 0; i < 7; i++) begin
         check_eq("t1_valid", 32'(bus3.data_valid), 32'd1);
         check_eq("t1_pat",   32'(bus3.data_out),   32'(exp7[i]));
         if (i == 6) begin bus3.start = 1'b1; bus3.seed = 3'b101; end
         tick();
      end
      bus3.start = 1'b0;
      check_eq("t1_complete", 32'(bus3.complete),   32'd1);
      check_eq("t1_busy_end", 32'(bus3.busy),       32'd0);
      check_eq("t1_valid_end", 32'(bus3.data_valid), 32'd0);
      check_eq("t1_hold_last", 32'(bus3.data_out),  32'd4);
      tick();
      check_eq("t1_stay_done", 32'(bus3.complete),  32'd1);

      // De Bruijn extension: all eight states, zero included.
      bus3z.seed = 3'b001; bus3z.start = 1'b1;
      tick();
      bus3z.start = 1'b0; bus3z.advance = 1'b1;
      seen3 = '0;
      for (int i = 0; i < 8; i++) begin
         check_eq("t2_valid", 32'(bus3z.data_valid), 32'd1);
         check_eq("t2_pat",   32'(bus3z.data_out),   32'(exp8z[i]));
         seen3[bus3z.data_out] = 1'b1;
         tick();
      end
      check_eq("t2_distinct", 32'(seen3),           32'hFF);
      check_eq("t2_complete", 32'(bus3z.complete),  32'd1);
      check_eq("t2_valid_end", 32'(bus3z.data_valid), 32'd0);
      bus3z.advance = 1'b0;

      // Zero seed substitution, then restart from DONE with seed 101.
      bus3.seed = 3'b000; bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0;
      check_eq("t3_seed_err", 32'(bus3.seed_err), 32'd1);
      check_eq("t3_complete_clr", 32'(bus3.complete), 32'd0);
      for (int i = 0; i < 7; i++) begin
         check_eq("t3_pat", 32'(bus3.data_out), 32'(exp7[i]));
         tick();
      end
      check_eq("t3_complete", 32'(bus3.complete), 32'd1);
      check_eq("t3_err_sticky", 32'(bus3.seed_err), 32'd1);
      bus3.seed = 3'b101; bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0;
      check_eq("t3_err_clr",  32'(bus3.seed_err),   32'd0);
      check_eq("t3_cpl_clr",  32'(bus3.complete),   32'd0);
      check_eq("t3_valid_up", 32'(bus3.data_valid), 32'd1);
      for (int i = 0; i < 7; i++) begin
         check_eq("t3_pat2", 32'(bus3.data_out), 32'(exp7[(i + 2) % 7]));
         tick();
      end
      check_eq("t3_complete2", 32'(bus3.complete), 32'd1);

      // Random stalls: order unchanged, complete only after the 7th accept.
      bus3.advance = 1'b0; bus3.seed = 3'b001; bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0;
      acc = 0; cyc = 0;
      while (acc < 7 && cyc < 200) begin
         adv = 1'($urandom_range(0, 1));
         bus3.advance = adv;
         tick();
         cyc++;
         if (adv) acc++;
         if (acc < 7) begin
            check_eq("t4_pat",    32'(bus3.data_out), 32'(exp7[acc]));
            check_eq("t4_no_cpl", 32'(bus3.complete), 32'd0);
         end
      end
      bus3.advance = 1'b0;
      check_eq("t4_accepts",  32'(acc),             32'd7);
      check_eq("t4_complete", 32'(bus3.complete),   32'd1);
      check_eq("t4_valid_end", 32'(bus3.data_valid), 32'd0);

      // Asynchronous reset at the fourth pattern, then a clean full run.
      bus3.seed = 3'b001; bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0; bus3.advance = 1'b1;
      repeat (3) tick();
      check_eq("t5_pat4", 32'(bus3.data_out), 32'd3);
      #2 reset = 1'b0;
      #1;
      check_eq("t5_rst_data",  32'(bus3.data_out),   32'd1);
      check_eq("t5_rst_valid", 32'(bus3.data_valid), 32'd0);
      check_eq("t5_rst_busy",  32'(bus3.busy),       32'd0);
      check_eq("t5_rst_cpl",   32'(bus3.complete),   32'd0);
      #2 reset = 1'b1;
      tick();
      check_eq("t5_idle_adv", 32'(bus3.data_valid), 32'd0);
      bus3.start = 1'b1;
      tick();
      bus3.start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         check_eq("t5_pat", 32'(bus3.data_out), 32'(exp7[i]));
         tick();
      end
      check_eq("t5_complete", 32'(bus3.complete), 32'd1);
      bus3.advance = 1'b0;

      // 8-bit maximal run with stray start pulses during RUN.
      bus8.seed = 8'h01; bus8.start = 1'b1; bus8.advance = 1'b1;
      tick();
      bus8.start = 1'b0;
      n = 0; cyc = 0; dups = 0; zeros = 0; seen8 = '0;
      while (bus8.data_valid && cyc < 400) begin
         if (n < 7) check_eq("t6_pat", 32'(bus8.data_out), 32'(exp8[n]));
         if (bus8.data_out == 8'h00) zeros++;
         if (seen8[bus8.data_out]) dups++;
         seen8[bus8.data_out] = 1'b1;
         n++;
         bus8.seed  = 8'h55;
         bus8.start = ((n % 17) == 0);
         tick();
         cyc++;
      end
      bus8.start = 1'b0; bus8.advance = 1'b0;
      check_eq("t6_count",    32'(n),              32'd255);
      check_eq("t6_dups",     32'(dups),           32'd0);
      check_eq("t6_zeros",    32'(zeros),          32'd0);
      check_eq("t6_complete", 32'(bus8.complete),  32'd1);
      check_eq("t6_busy_end", 32'(bus8.busy),      32'd0);
      check_eq("t6_last",     32'(bus8.data_out),  32'h80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
